// File: rtl/afifo_pkt_writer.sv
// afifo_pkt_writer: store-and-forward packet framer feeding the async FIFO write port.
// Collects one packet from a valid/ready stream, then writes a length header and the
// payload, stalling on fifo_full. Define AFIFO_PKT_TRAILER_EN to append an XOR checksum
// trailer word after the payload.
module afifo_pkt_writer #(
  parameter int W = 8,
  parameter int MAX_LEN = 16,
  localparam int LW = $clog2(MAX_LEN)
) (
  input  logic         wr_clk,
  input  logic         wr_reset_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  input  logic         s_last,
  output logic         fifo_wr_en,
  output logic [W-1:0] fifo_wr_data,
  input  logic         fifo_full,
  output logic         pkt_sent,
  output logic         trunc_err
);
`ifdef AFIFO_PKT_TRAILER_EN
  typedef enum logic [2:0] {INIT, COLLECT, HDR, BODY, TRLR} state_t;
  logic [W-1:0] csum;
`else
  typedef enum logic [2:0] {INIT, COLLECT, HDR, BODY} state_t;
`endif
  localparam logic [LW:0] ONE = (LW + 1)'(1);
  localparam logic [LW:0] LAST = (LW + 1)'(MAX_LEN - 1);
  state_t state;
  logic [LW:0] len, idx;
  logic [W-1:0] mem [MAX_LEN];
  logic last_body;
  assign s_ready = state == COLLECT;
  assign last_body = idx == len - ONE;
`ifdef AFIFO_PKT_TRAILER_EN
  assign fifo_wr_en = (state == HDR || state == BODY || state == TRLR) && !fifo_full;
  assign pkt_sent = state == TRLR && !fifo_full;
`else
  assign fifo_wr_en = (state == HDR || state == BODY) && !fifo_full;
  assign pkt_sent = state == BODY && last_body && !fifo_full;
`endif
  // Egress word mux: header carries the payload length, body reads the buffer.
  always_comb begin
`ifdef AFIFO_PKT_TRAILER_EN
    fifo_wr_data = state == HDR  ? W'(len) :
                   state == BODY ? mem[idx[LW-1:0]] :
                   state == TRLR ? csum : '0;
`else
    fifo_wr_data = state == HDR  ? W'(len) :
                   state == BODY ? mem[idx[LW-1:0]] : '0;
`endif
  end
  // Payload buffer; contents are only meaningful below len, so no reset is needed.
  always_ff @(posedge wr_clk) begin
    if (state == COLLECT && s_valid) mem[len[LW-1:0]] <= s_data;
  end
  // Framing FSM: collect a packet, then drain header and body under fifo_full backpressure.
  always_ff @(posedge wr_clk or negedge wr_reset_n) begin
    if (!wr_reset_n) begin
      state <= INIT;
      len <= '0;
      idx <= '0;
      trunc_err <= 1'b0;
`ifdef AFIFO_PKT_TRAILER_EN
      csum <= '0;
`endif
    end else begin
      trunc_err <= 1'b0;
      case (state)
        INIT: state <= COLLECT;
        COLLECT: if (s_valid) begin
          len <= len + ONE;
`ifdef AFIFO_PKT_TRAILER_EN
          csum <= (len == '0 ? '0 : csum) ^ s_data;
`endif
          if (s_last || len == LAST) begin
            state <= HDR;
            trunc_err <= len == LAST;
          end
        end
        HDR: if (!fifo_full) begin
          idx <= '0;
          state <= BODY;
        end
        BODY: if (!fifo_full) begin
          idx <= idx + ONE;
          if (last_body) begin
            len <= '0;
`ifdef AFIFO_PKT_TRAILER_EN
            state <= TRLR;
`else
            state <= COLLECT;
`endif
          end
        end
`ifdef AFIFO_PKT_TRAILER_EN
        TRLR: if (!fifo_full) state <= COLLECT;
`endif
        default: state <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_afifo_pkt_writer.sv
// tb_afifo_pkt_writer: scoreboard bench for afifo_pkt_writer (W=8, MAX_LEN=16).
module tb_afifo_pkt_writer;
  logic wr_clk = 1'b0;
  logic wr_reset_n = 1'b0;
  logic s_valid = 1'b0;
  logic s_last = 1'b0;
  logic fifo_full = 1'b0;
  logic [7:0] s_data = '0;
  logic s_ready, fifo_wr_en, pkt_sent, trunc_err;
  logic [7:0] fifo_wr_data;
  int checks = 0;
  int fails = 0;
  int trunc_seen = 0;
  int trunc_exp = 0;
`ifdef AFIFO_PKT_TRAILER_EN
  localparam int TRL = 1;
`else
  localparam int TRL = 0;
`endif
  typedef struct packed {logic [7:0] d; logic ps;} exp_t;
  typedef struct {int n; logic [7:0] d[4]; logic [7:0] hdr; logic [7:0] trl;} vec_t;
  exp_t exp_q[$];
  logic [7:0] pw[$];
  vec_t tbl[4];

  afifo_pkt_writer dut (
    .wr_clk(wr_clk), .wr_reset_n(wr_reset_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full),
    .pkt_sent(pkt_sent), .trunc_err(trunc_err)
  );

  always #5 wr_clk = ~wr_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge wr_clk);
    #1;
  endtask

  function automatic logic [7:0] pw_xor();
    logic [7:0] x = '0;
    foreach (pw[i]) x ^= pw[i];
    return x;
  endfunction

  task automatic expect_pkt(input logic [7:0] hdr, input logic [7:0] trl);
    exp_q.push_back('{hdr, 1'b0});
    foreach (pw[i]) exp_q.push_back('{pw[i], 1'(TRL == 0 && i == pw.size() - 1)});
    if (TRL != 0) exp_q.push_back('{trl, 1'b1});
  endtask

  task automatic send_word(input logic [7:0] d, input logic l);
    int t = 0;
    s_valid = 1'b1;
    s_data = d;
    s_last = l;
    @(negedge wr_clk);
    while (!s_ready && t < 200) begin
      tick();
      @(negedge wr_clk);
      t++;
    end
    if (!s_ready) begin
      fails++;
      $display("FAIL send_timeout: s_ready got 0, expected 1 within 200 cycles");
    end
    tick();
  endtask

  task automatic send_pw;
    foreach (pw[i]) send_word(pw[i], 1'(i == pw.size() - 1));
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic wait_drain;
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      tick();
      t++;
    end
    @(negedge wr_clk);
    chk("drain", exp_q.size(), 0);
    tick();
  endtask

  // Scoreboard: every FIFO write is popped and compared, pkt_sent must match the entry.
  always @(negedge wr_clk) begin
    exp_t e;
    if (wr_reset_n) begin
      if (trunc_err) trunc_seen++;
      if (fifo_wr_en) begin
        chk("wr_en_while_full", fifo_full, 0);
        chk("ingress_egress_overlap", s_ready, 0);
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_write: got data 0x%0h, expected no write", fifo_wr_data);
        end else begin
          e = exp_q.pop_front();
          chk("fifo_data", fifo_wr_data, e.d);
          chk("pkt_sent", pkt_sent, e.ps);
        end
      end else chk("pkt_sent_idle", pkt_sent, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{1, '{8'hA5, 8'h00, 8'h00, 8'h00}, 8'h01, 8'hA5};
    tbl[1] = '{3, '{8'h11, 8'h22, 8'h33, 8'h00}, 8'h03, 8'h00};
    tbl[2] = '{4, '{8'h01, 8'h02, 8'h04, 8'h08}, 8'h04, 8'h0F};
    tbl[3] = '{2, '{8'hFF, 8'h0F, 8'h00, 8'h00}, 8'h02, 8'hF0};
    @(negedge wr_clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_wr_data", fifo_wr_data, 0);
    chk("rst_pkt_sent", pkt_sent, 0);
    chk("rst_trunc_err", trunc_err, 0);
    tick();
    wr_reset_n = 1'b1;
    @(negedge wr_clk);
    chk("init_s_ready", s_ready, 0);
    @(negedge wr_clk);
    chk("first_s_ready", s_ready, 1);
    tick();
    foreach (tbl[v]) begin
      pw.delete();
      for (int i = 0; i < tbl[v].n; i++) pw.push_back(tbl[v].d[i]);
      expect_pkt(tbl[v].hdr, tbl[v].trl);
      send_pw();
      for (int k = 0; k < tbl[v].n + 1 + TRL; k++) begin
        @(negedge wr_clk);
        chk("b2b_wr_en", fifo_wr_en, 1);
        chk("ingress_closed", s_ready, 0);
        tick();
      end
      @(negedge wr_clk);
      chk("s_ready_return", s_ready, 1);
      chk("vec_queue_empty", exp_q.size(), 0);
      tick();
    end
    pw.delete();
    for (int i = 1; i <= 16; i++) pw.push_back(8'(i));
    expect_pkt(8'h10, pw_xor());
    trunc_exp++;
    pw.delete();
    pw.push_back(8'd17);
    expect_pkt(8'h01, 8'd17);
    for (int i = 1; i <= 16; i++) send_word(8'(i), 1'b0);
    @(negedge wr_clk);
    chk("trunc_err_hdr", trunc_err, 1);
    tick();
    @(negedge wr_clk);
    chk("trunc_err_pulse", trunc_err, 0);
    tick();
    send_word(8'd17, 1'b1);
    s_valid = 1'b0;
    s_last = 1'b0;
    wait_drain();
    pw.delete();
    pw = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    expect_pkt(8'h04, pw_xor());
    send_pw();
    repeat (3) tick();
    fifo_full = 1'b1;
    repeat (5) begin
      @(negedge wr_clk);
      chk("stall_wr_en", fifo_wr_en, 0);
      chk("stall_s_ready", s_ready, 0);
      tick();
    end
    fifo_full = 1'b0;
    wait_drain();
    fifo_full = 1'b1;
    pw = '{8'hD1, 8'hD2, 8'hD3};
    expect_pkt(8'h03, pw_xor());
    send_pw();
    repeat (3) begin
      @(negedge wr_clk);
      chk("hdr_stall_wr_en", fifo_wr_en, 0);
      tick();
    end
    fifo_full = 1'b0;
    for (int k = 0; k < 4 + TRL; k++) begin
      @(negedge wr_clk);
      chk("hdr_release_b2b", fifo_wr_en, 1);
      tick();
    end
    wait_drain();
    pw = '{8'hE1, 8'hE2, 8'hE3, 8'hE4};
    expect_pkt(8'h04, pw_xor());
    send_pw();
    repeat (3) tick();
    wr_reset_n = 1'b0;
    #1;
    chk("midrst_s_ready", s_ready, 0);
    chk("midrst_wr_en", fifo_wr_en, 0);
    chk("midrst_wr_data", fifo_wr_data, 0);
    chk("midrst_pkt_sent", pkt_sent, 0);
    chk("midrst_trunc_err", trunc_err, 0);
    exp_q.delete();
    tick();
    wr_reset_n = 1'b1;
    pw = '{8'h5A};
    expect_pkt(8'h01, 8'h5A);
    send_pw();
    wait_drain();
    chk("trunc_count", trunc_seen, trunc_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
